// File: rtl/sar_conv_ctrl.sv
// Successive-approximation ADC conversion controller: round-robin channel
// arbitration, sample/hold sequencing and an MSB-first binary search on the DAC.
module sar_conv_ctrl #(
  parameter  int N_CH          = 4,
  parameter  int WIDTH         = 8,
  parameter  int SAMPLE_CYCLES = 4,
  localparam int CW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_CH-1:0]  i_ch_req,
  input  logic             i_cmp,
  output logic [CW-1:0]    o_mux_sel,
  output logic             o_sample,
  output logic [WIDTH-1:0] o_dac_code,
  output logic             o_busy,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res_data,
  output logic [CW-1:0]    o_res_ch,
  output logic [N_CH-1:0]  o_ch_ack
);

  localparam int BW = $clog2(WIDTH);
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  // Returns {found, channel}: first requester searching upward from last+1.
  function automatic logic [CW:0] rr_pick(input logic [N_CH-1:0] req,
                                          input logic [CW-1:0]   last);
    logic [CW:0] pick;
    int          idx;
    pick = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(last) + k) % N_CH;
      if (req[idx]) pick = {1'b1, CW'(idx)};
    end
    return pick;
  endfunction

  state_t           r_state, w_state_nx;
  logic [SW-1:0]    r_cnt, w_cnt_nx;
  logic [BW-1:0]    r_bit, w_bit_nx;
  logic [WIDTH-1:0] r_code, w_code_nx;
  logic [CW-1:0]    r_mux, w_mux_nx;
  logic             r_sample, w_sample_nx;
  logic             r_busy, w_busy_nx;
  logic             r_res_valid, w_res_valid_nx;
  logic [WIDTH-1:0] r_res_data, w_res_data_nx;
  logic [CW-1:0]    r_res_ch, w_res_ch_nx;
  logic [N_CH-1:0]  r_ack, w_ack_nx;
  logic [CW-1:0]    r_last, w_last_nx;
  logic [CW:0]      w_pick;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_kept;

  assign w_pick = rr_pick(i_ch_req, r_last);
  assign w_mask = WIDTH'(1) << r_bit;
  assign w_kept = i_cmp ? r_code : (r_code & ~w_mask);

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_bit_nx       = r_bit;
    w_code_nx      = r_code;
    w_mux_nx       = r_mux;
    w_sample_nx    = r_sample;
    w_res_valid_nx = 1'b0;
    w_res_data_nx  = r_res_data;
    w_res_ch_nx    = r_res_ch;
    w_ack_nx       = '0;
    w_last_nx      = r_last;
    case (r_state)
      ST_IDLE: begin
        w_code_nx = MSB_CODE;
        if (w_pick[CW]) begin
          w_mux_nx    = w_pick[CW-1:0];
          w_sample_nx = 1'b1;
          w_cnt_nx    = '0;
          w_state_nx  = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_code_nx = MSB_CODE;
        if (r_cnt == SW'(SAMPLE_CYCLES - 1)) begin
          w_sample_nx = 1'b0;
          w_bit_nx    = BW'(WIDTH - 1);
          w_state_nx  = ST_CONVERT;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_CONVERT: begin
        // After bit 0 the register holds the final code for the DONE cycle.
        if (r_bit == '0) begin
          w_code_nx  = w_kept;
          w_state_nx = ST_DONE;
        end else begin
          w_code_nx = w_kept | (w_mask >> 1);
          w_bit_nx  = r_bit - 1'b1;
        end
      end
      ST_DONE: begin
        w_res_valid_nx = 1'b1;
        w_res_data_nx  = r_code;
        w_res_ch_nx    = r_mux;
        w_ack_nx       = N_CH'(1) << r_mux;
        w_last_nx      = r_mux;
        w_code_nx      = MSB_CODE;
        w_state_nx     = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_code      <= MSB_CODE;
      r_mux       <= '0;
      r_sample    <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      r_ack       <= '0;
      r_last      <= CW'(N_CH - 1);
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit       <= w_bit_nx;
      r_code      <= w_code_nx;
      r_mux       <= w_mux_nx;
      r_sample    <= w_sample_nx;
      r_busy      <= w_busy_nx;
      r_res_valid <= w_res_valid_nx;
      r_res_data  <= w_res_data_nx;
      r_res_ch    <= w_res_ch_nx;
      r_ack       <= w_ack_nx;
      r_last      <= w_last_nx;
    end
  end

  assign o_mux_sel   = r_mux;
  assign o_sample    = r_sample;
  assign o_dac_code  = r_code;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_ch    = r_res_ch;
  assign o_ch_ack    = r_ack;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Randomized bench for sar_conv_ctrl with a transaction-level timeline model
// and a few hand-computed directed expectations.
module tb_sar_conv_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ch_req = '0;
  logic         cmp;
  logic [1:0]   mux_sel;
  logic         sample;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic [1:0]   res_ch;
  logic [N-1:0] ch_ack;

  logic [W-1:0] ana [N];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0] t1_seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  int t2_order [5] = '{0, 1, 2, 3, 0};
  int t6_order [4] = '{0, 3, 0, 3};

  always #5 clk = ~clk;

  // Ideal comparator against the held analog value of the selected channel.
  assign cmp = (ana[mux_sel] >= dac_code);

  sar_conv_ctrl #(.N_CH(N), .WIDTH(W), .SAMPLE_CYCLES(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_req(ch_req), .i_cmp(cmp),
    .o_mux_sel(mux_sel), .o_sample(sample), .o_dac_code(dac_code),
    .o_busy(busy), .o_res_valid(res_valid), .o_res_data(res_data),
    .o_res_ch(res_ch), .o_ch_ack(ch_ack)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected trial code for trial j: the analog value's bits above the
  // trial bit, plus the trial bit itself.
  function automatic int exp_dac(input int j, input int a);
    int b;
    int upper;
    b = W - 1 - j;
    upper = ('hFF << (b + 1)) & 'hFF;
    return (a & upper) | (1 << b);
  endfunction

  // Model: m_t counts edges since the grant edge.
  bit m_active = 1'b0;
  int m_t = 0, m_ch = 0, m_ana = 0, m_last = N - 1;
  int m_mux = 0, m_rv = 0, m_rd = 0, m_rc = 0, m_ack = 0;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_t = 0; m_last = N - 1;
      m_mux = 0; m_rv = 0; m_rd = 0; m_rc = 0; m_ack = 0;
    end else begin
      m_rv = 0;
      m_ack = 0;
      if (m_active) begin
        m_t++;
        if (m_t == S + W + 1) begin
          m_active = 1'b0;
          m_rv = 1; m_rd = m_ana; m_rc = m_ch;
          m_ack = 1 << m_ch; m_last = m_ch;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (ch_req[c]) begin
            m_active = 1'b1; m_t = 0; m_ch = c; m_mux = c; m_ana = int'(ana[c]);
            break;
          end
        end
      end
    end
  end

  always begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy", busy, int'(m_active));
      chk("sample", sample, int'(m_active && m_t < S));
      chk("mux_sel", mux_sel, m_mux);
      if (!m_active || m_t < S) chk("dac_rest", dac_code, 'h80);
      else if (m_t < S + W) chk("dac_trial", dac_code, exp_dac(m_t - S, m_ana));
      chk("res_valid", res_valid, m_rv);
      chk("res_data", res_data, m_rd);
      chk("res_ch", res_ch, m_rc);
      chk("ch_ack", ch_ack, m_ack);
      if (res_valid) $display("POST ch=%0d data=%02h ack=%b t=%0t", res_ch, res_data, ch_ack, $time);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("busy_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cyc++;
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int cyc, n, prev;
    for (int c = 0; c < N; c++) ana[c] = '0;
    step(); step();
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_dac", dac_code, 'h80);
    chk("rst_res_data", res_data, 0);
    chk("rst_ack", ch_ack, 0);
    rst_n = 1'b1;
    step();

    // Single conversion on channel 2, analog 0xA5.
    ana[2] = 8'hA5;
    ch_req = 4'b0100;
    wait_busy();
    ch_req = '0;
    chk("t1_mux", mux_sel, 2);
    repeat (S) step();
    for (int j = 0; j < 8; j++) begin
      chk("t1_dac_seq", dac_code, t1_seq[j]);
      step();
    end
    chk("t1_valid_early", res_valid, 0);
    step();
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 'hA5);
    chk("t1_ch", res_ch, 2);
    chk("t1_ack", ch_ack, 4'b0100);

    // All channels requesting from a fresh reset.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int c = 0; c < N; c++) ana[c] = W'($urandom);
    ch_req = 4'b1111;
    n = 0; prev = 0;
    for (int i = 1; i <= 100 && n < 5; i++) begin
      step();
      if (res_valid) begin
        chk("t2_order", res_ch, t2_order[n]);
        chk("t2_onehot", $countones(ch_ack), 1);
        if (n > 0) chk("t2_gap", i - prev, 14);
        prev = i;
        n++;
        if (n == 5) ch_req = '0;
      end
    end
    if (n < 5) chk("t2_timeout", n, 5);
    ch_req = '0;

    // Extremes on channel 1.
    ana[1] = 8'h00; ch_req = 4'b0010;
    wait_valid(cyc); ch_req = '0;
    chk("t3_zero", res_data, 'h00);
    ana[1] = 8'hFF; ch_req = 4'b0010;
    wait_valid(cyc); ch_req = '0;
    chk("t3_full", res_data, 'hFF);
    chk("t3_ch", res_ch, 1);

    // Reset during the fourth CONVERT cycle.
    ana[0] = 8'h5A; ch_req = 4'b0001;
    wait_busy();
    ch_req = '0;
    repeat (S + 3) step();
    rst_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_sample", sample, 0);
    chk("t4_mux", mux_sel, 0);
    chk("t4_dac", dac_code, 'h80);
    chk("t4_valid", res_valid, 0);
    chk("t4_data", res_data, 0);
    chk("t4_ch", res_ch, 0);
    chk("t4_ack", ch_ack, 0);
    step(); step();
    ana[3] = 8'h3C; ch_req = 4'b1000; rst_n = 1'b1;
    wait_valid(cyc); ch_req = '0;
    chk("t4_post_ch", res_ch, 3);
    chk("t4_post_data", res_data, 'h3C);

    // Request dropped during SAMPLE still completes.
    ana[1] = 8'h77; ch_req = 4'b0010;
    wait_busy();
    step();
    ch_req = '0;
    wait_valid(cyc);
    chk("t5_ch", res_ch, 1);
    chk("t5_data", res_data, 'h77);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_idle", busy, 0);
    end

    // Fairness between channels 0 and 3 after channel 3 was served.
    ch_req = 4'b1000;
    wait_valid(cyc);
    ch_req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wait_valid(cyc);
      chk("t6_order", res_ch, t6_order[i]);
    end
    ch_req = '0;

    // Random traffic; analog values never change under an active conversion.
    for (int i = 0; i < 2500; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) ch_req = N'($urandom);
      for (int c = 0; c < N; c++)
        if (!(busy && int'(mux_sel) == c) && $urandom_range(0, 3) == 0) ana[c] = W'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_conv_ctrl.md
# sar_conv_ctrl

Conversion controller for the 8-bit successive-approximation ADC. It arbitrates round-robin among several analog input channels and drives the analog mux and sample/hold. It runs the MSB-first binary search on the DAC using the comparator result, then posts each finished code with its channel number. It sits between the channel requesters and the analog front end (mux, S/H, DAC, comparator).

## Interface
Parameters:
- N_CH, 4: number of analog channels; legal range 2..16.
- WIDTH, 8: conversion resolution in bits.
- SAMPLE_CYCLES, 4: S/H tracking duration in clocks; must be ≥1.
- CW = clog2(N_CH): derived, channel-index width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; a low level forces the reset state immediately.
- ch_req  in  N_CH  per-channel conversion request, level-sensitive.
- cmp  in  1  comparator result: 1 = held input ≥ dac_code.
- mux_sel  out  CW  analog mux channel select.
- sample  out  1  S/H control: 1 = track, 0 = hold.
- dac_code  out  WIDTH  current DAC trial code.
- busy  out  1  high whenever state ≠ IDLE.
- res_valid  out  1  one-cycle pulse when a result is posted.
- res_data  out  WIDTH  converted code; holds its value until the next post.
- res_ch  out  CW  channel of res_data.
- ch_ack  out  N_CH  one-hot, one-cycle pulse marking the channel just served; coincident with res_valid.

## Operation
- States: IDLE → SAMPLE → CONVERT → DONE → IDLE.
- IDLE:
  - If any ch_req bit is 1, grant the first requesting channel found searching upward from (last_grant+1) mod N_CH.
  - Latch the grant into mux_sel, set sample=1, go to SAMPLE.
  - If no request is present, stay in IDLE.
- SAMPLE:
  - Lasts SAMPLE_CYCLES clocks; mux_sel is held stable.
  - On exit: sample=0, bit index i=WIDTH-1, dac_code = 1<<(WIDTH-1), go to CONVERT.
- CONVERT:
  - Lasts WIDTH clocks. In each clock, dac_code = kept bits | (1<<i).
  - At the edge, bit i is kept if cmp=1 and cleared if cmp=0, then i decrements.
  - After bit 0 is resolved, go to DONE.
- DONE (1 clock):
  - res_valid=1, res_data = final code, res_ch = mux_sel, ch_ack[mux_sel]=1.
  - last_grant is updated to mux_sel. Go to IDLE.
- Arithmetic: all codes are unsigned WIDTH-bit; no bit beyond WIDTH-1 is ever written.
- Boundary conditions:
  - A ch_req bit that drops after its grant does not cancel the conversion; the result is still posted.
  - A new or changed ch_req during a conversion is considered only in the next IDLE.
  - ch_req is not sampled in DONE, so there is no back-to-back grant.
  - Only one channel is granted per conversion, even when all channels are requesting.
- Reset (any time, including mid-conversion):
  - state=IDLE, sample=0, mux_sel=0, dac_code = 1<<(WIDTH-1) (128), busy=0.
  - res_valid=0, res_data=0, res_ch=0, ch_ack=0.
  - last_grant = N_CH-1, so channel 0 has first priority.
  - An aborted conversion never produces res_valid.
- dac_code returns to 1<<(WIDTH-1) in IDLE and SAMPLE.

## Timing
- Edge E0: the first edge in IDLE that sees a request. busy, sample and mux_sel are valid after E0.
- sample falls at edge E0+SAMPLE_CYCLES.
- CONVERT bit WIDTH-1 occupies the cycle after E0+SAMPLE_CYCLES.
- cmp must be settled before each rising edge in CONVERT. cmp is ignored in all other states.
- res_valid, res_data, res_ch and ch_ack update at edge E0+SAMPLE_CYCLES+WIDTH+1. res_valid and ch_ack stay high for exactly one clock.
- Next possible grant edge: E0+SAMPLE_CYCLES+WIDTH+2, i.e. a throughput of one conversion per 14 clocks with default parameters.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single request, ch_req=4'b0100, comparator modelled against analog value 0xA5 → res_valid 13 clocks after E0 with res_data=0xA5, res_ch=2, ch_ack=4'b0100. dac_code trial sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- ch_req=4'b1111 held for 5 conversions → res_ch order 0,1,2,3,0; consecutive res_valid pulses 14 clocks apart; exactly one ch_ack bit per post.
- Analog value 0x00 and then 0xFF on channel 1 → res_data=0x00 and res_data=0xFF.
- reset driven low in the 4th CONVERT cycle → all outputs at reset values immediately and no res_valid. After reset is released with ch_req=4'b1000, channel 3 converts with res_ch=3.
- ch_req=4'b0010 dropped during SAMPLE → conversion completes and the ch1 result is posted. The following IDLE with ch_req=0 stays idle and busy=0.
- Round-robin fairness with ch_req=4'b1001 after ch3 was served → grant ch0, then ch3, alternating.
